// File: rtl/param_match_counter.sv
// param_match_counter: parametrised timebase counter with per-channel compare flags,
// midpoint flag, registered wrap pulse and sticky one-shot done flag.
// Latency: COUNT/WRAP/DONE update on the rising edge; MATCH/HALF are combinational on COUNT/CMP.
// Backpressure: none; EN gates advancement, CLR overrides everything on the next edge.
//
// Ports:
//   i_clock    system clock (rising edge)
//   i_reset_n  asynchronous active-low reset
//   i_en       count enable
//   i_clr      synchronous clear (priority over everything else)
//   i_mode     00 free-run, 01 auto-reload, 10 one-shot, 11 free-run
//   i_cmp      packed compare values, channel i = i_cmp[i*WIDTH +: WIDTH]; channel 0 is terminal
//   o_count    present counter value
//   o_match    per-channel equality flags
//   o_half     counter equals 2^(WIDTH-1)
//   o_wrap     one-cycle pulse in the cycle the counter first shows 0 after rollover/reload
//   o_done     one-shot terminal reached (sticky until clear/reset)
module param_match_counter #(
  parameter int WIDTH    = 20,
  parameter int CHANNELS = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_en,
  input  logic                      i_clr,
  input  logic [1:0]                i_mode,
  input  logic [CHANNELS*WIDTH-1:0] i_cmp,
  output logic [WIDTH-1:0]          o_count,
  output logic [CHANNELS-1:0]       o_match,
  output logic                      o_half,
  output logic                      o_wrap,
  output logic                      o_done
);

  localparam logic [1:0]       MODE_RELOAD  = 2'b01;
  localparam logic [1:0]       MODE_ONESHOT = 2'b10;
  localparam logic [WIDTH-1:0] HALF_VAL     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_done;

  logic [WIDTH-1:0] w_cmp0;
  logic             w_term;
  logic             w_all_ones;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             w_done_nxt;

  assign w_cmp0     = i_cmp[WIDTH-1:0];
  assign w_term     = (r_count == w_cmp0);
  assign w_all_ones = &r_count;

  // Next-state selection: CLR > DONE hold > EN > idle.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = r_done;
    if (i_clr) begin
      w_count_nxt = '0;
      w_done_nxt  = 1'b0;
    end else if (r_done) begin
      w_count_nxt = r_count;
    end else if (i_en) begin
      case (i_mode)
        MODE_RELOAD: begin
          if (w_term) begin
            w_count_nxt = '0;
            w_wrap_nxt  = 1'b1;
          end else begin
            // Natural rollover still pulses WRAP if CMP[0] was moved below COUNT mid-run.
            w_count_nxt = r_count + ONE;
            w_wrap_nxt  = w_all_ones;
          end
        end
        MODE_ONESHOT: begin
          if (w_term) begin
            w_done_nxt = 1'b1;
          end else begin
            w_count_nxt = r_count + ONE;
            w_wrap_nxt  = w_all_ones;
          end
        end
        default: begin
          w_count_nxt = r_count + ONE;
          w_wrap_nxt  = w_all_ones;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Compare flags are live on CMP: no capture register, changes show immediately.
  always_comb begin
    o_match = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      o_match[i] = (r_count == i_cmp[i*WIDTH +: WIDTH]);
    end
  end

  assign o_half  = (r_count == HALF_VAL);
  assign o_count = r_count;
  assign o_wrap  = r_wrap;
  assign o_done  = r_done;

endmodule
